// File: rtl/tft_timing_ctrl.sv
// TFT panel timing generator for an 800x480 RGB565 panel.
// Free-running horizontal/vertical counters produce a combinational pixel
// request (with active-area coordinates) toward the upstream pixel source.
// The returned pixel and HS/VS/DE are registered together, so everything on
// the panel pins lags the counter state by exactly one clock and stays aligned.
module tft_timing_ctrl #(
  parameter int H_SYNC  = 128,
  parameter int H_BACK  = 88,
  parameter int H_DISP  = 800,
  parameter int H_FRONT = 40,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_DISP  = 480,
  parameter int V_FRONT = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] Data_in,
  output logic        Data_req,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic [15:0] TFT_rgb,
  output logic        TFT_hs,
  output logic        TFT_vs,
  output logic        TFT_de,
  output logic        TFT_clk,
  output logic        TFT_BL
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_SYNC_END = 11'(H_SYNC);
  localparam logic [10:0] H_START    = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_END      = 11'(H_SYNC + H_BACK + H_DISP);

  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_SYNC_END = 10'(V_SYNC);
  localparam logic [9:0]  V_START    = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  V_END      = 10'(V_SYNC + V_BACK + V_DISP);

  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic        hact, vact, req;

  logic        de_q, de_d;
  logic [15:0] rgb_q, rgb_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        bl_q, bl_d;

  // Next counter values: line wrap advances the line counter, which wraps at frame end.
  always_comb begin
    hcnt_d = hcnt_q + 11'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = 11'd0;
      if (vcnt_q == V_LAST) begin
        vcnt_d = 10'd0;
      end else begin
        vcnt_d = vcnt_q + 10'd1;
      end
    end
  end

  // Counter registers; reset parks the raster at the start of a frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hcnt_q <= 11'd0;
      vcnt_q <= 10'd0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  // Pixel request and active-area coordinates, decoded straight from the counters.
  always_comb begin
    hact   = (hcnt_q >= H_START) && (hcnt_q < H_END);
    vact   = (vcnt_q >= V_START) && (vcnt_q < V_END);
    req    = hact && vact && !Reset;
    hcount = 11'd0;
    vcount = 10'd0;
    if (req) begin
      hcount = hcnt_q - H_START;
      vcount = vcnt_q - V_START;
    end
  end

  // Panel-side next values; the pixel bus is blanked to zero outside the active window.
  always_comb begin
    de_d  = req;
    rgb_d = req ? Data_in : 16'h0000;
    hs_d  = (hcnt_q >= H_SYNC_END);
    vs_d  = (vcnt_q >= V_SYNC_END);
    bl_d  = 1'b1;
  end

  // Panel output registers; syncs idle high and backlight stays off while in reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      de_q  <= 1'b0;
      rgb_q <= 16'h0000;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      bl_q  <= 1'b0;
    end else begin
      de_q  <= de_d;
      rgb_q <= rgb_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      bl_q  <= bl_d;
    end
  end

  assign Data_req = req;
  assign TFT_de   = de_q;
  assign TFT_rgb  = rgb_q;
  assign TFT_hs   = hs_q;
  assign TFT_vs   = vs_q;
  assign TFT_BL   = bl_q;
  assign TFT_clk  = Clk;

endmodule
